// File: rtl/ode_run_controller.sv
// ode_run_controller: sequences one integrator run (prime, step, drain) and
// streams decimated y samples through a 1-entry valid/ready output register.
// Optional feature: define ODE_ABORT_EN to add the abort input.
module ode_run_controller #(
  parameter int WIDTH   = 18,
  parameter int STEP_W  = 16,
  parameter int DECIM_W = 8
) (
  input  logic                    clk,
  input  logic                    master_rst,
  input  logic                    start,
  input  logic [STEP_W-1:0]       num_steps,
  input  logic [DECIM_W-1:0]      decim,
`ifdef ODE_ABORT_EN
  input  logic                    abort,
`endif
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    int_run,
  output logic                    dy_en,
  output logic                    busy,
  output logic                    done,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic signed [WIDTH-1:0] sample_data
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, WAIT, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [STEP_W-1:0]  nsteps_q, steps_done;
  logic [DECIM_W-1:0] decim_q, dec_cnt;
  logic               prime_cnt;
  logic               cap_due;
  logic               cap_fire;
  logic               wrap, last_step, abort_req;

  // A programmed decimation of 0 behaves as 1 (every step sampled).
  function automatic logic [DECIM_W-1:0] eff_decim(input logic [DECIM_W-1:0] d);
    return (d == '0) ? DECIM_W'(1) : d;
  endfunction

`ifdef ODE_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign wrap      = (dec_cnt == decim_q - DECIM_W'(1));
  assign last_step = (steps_done == nsteps_q - STEP_W'(1));

  // Next-state and control outputs; a due capture that cannot land freezes dy
  always_comb begin
    cap_fire  = cap_due && (!sample_valid || sample_ready);
    state_nxt = state;
    int_run   = 1'b0;
    dy_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num_steps == '0) ? DONE : PRIME;
      end
      PRIME: begin
        int_run = 1'b1;
        if (prime_cnt) state_nxt = RUN;
      end
      RUN: begin
        int_run = 1'b1;
        dy_en   = !(cap_due && !cap_fire);
        if (dy_en && last_step) state_nxt = DRAIN;
        else if (!dy_en)        state_nxt = WAIT;
      end
      WAIT: begin
        int_run = 1'b1;
        if (cap_fire) state_nxt = RUN;
      end
      DRAIN: begin
        int_run = 1'b1;
        if (!cap_due && (!sample_valid || sample_ready)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_req) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) state <= IDLE;
    else            state <= state_nxt;
  end

  // Run configuration latch, prime timer, step and decimation counters
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      nsteps_q   <= '0;
      decim_q    <= '0;
      steps_done <= '0;
      dec_cnt    <= '0;
      prime_cnt  <= 1'b0;
    end else if (state == IDLE) begin
      steps_done <= '0;
      dec_cnt    <= '0;
      prime_cnt  <= 1'b0;
      if (start) begin
        nsteps_q <= num_steps;
        decim_q  <= eff_decim(decim);
      end
    end else begin
      if (state == PRIME) prime_cnt <= 1'b1;
      if (dy_en) begin
        steps_done <= steps_done + STEP_W'(1);
        dec_cnt    <= wrap ? '0 : dec_cnt + DECIM_W'(1);
      end
    end
  end

  // Capture scheduling and the 1-entry output register
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      cap_due      <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else if (abort_req) begin
      cap_due      <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      cap_due <= (cap_due && !cap_fire) || (dy_en && wrap);
      if (cap_fire) begin
        sample_valid <= 1'b1;
        sample_data  <= y_in;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ode_run_controller.md
# ode_run_controller

Sequencer that owns one integrator (or a lock-stepped bank sharing the same controls) inside the ODE solver datapath. On a start command from the NIOS II register interface it loads the initial condition, runs a programmed number of integration steps, and streams decimated samples of y to a valid/ready consumer. It stalls integration under back-pressure and reports busy/done. It drives the integrator's run input and a dy gate; the integrator's own arithmetic is untouched.

## Interface
Parameters:
- WIDTH, 18, width of y samples (matches the integrator's y)
- STEP_W, 16, width of the step counter and num_steps
- DECIM_W, 8, width of the decimation register

Ports:
- clk  in  1  system clock
- master_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- num_steps  in  STEP_W  integration steps per run; sampled on accepted start
- decim  in  DECIM_W  emit one sample every decim steps; 0 is treated as 1; sampled on accepted start
- abort  in  1  stop the current run (present only with ODE_ABORT_EN)
- y_in  in  WIDTH signed  integrator output y
- int_run  out  1  to the integrator's reset input; 0 holds y at the initial condition, 1 integrates
- dy_en  out  1  dy gate; the datapath applies dy when 1 and 0 when 0
- busy  out  1  high from accepted start until DONE is left
- done  out  1  one-cycle pulse when a run completes
- sample_valid  out  1  sample available
- sample_ready  in  1  consumer accepts sample
- sample_data  out  WIDTH signed  captured y

## Operation
- States: IDLE, PRIME, RUN, WAIT, DRAIN, DONE.
- IDLE: int_run=0, dy_en=0, busy=0. On start, latch num_steps and decim (effective decim: 0→1). Then:
  - num_steps=0: go to DONE.
  - Otherwise: go to PRIME.
- PRIME: int_run=1, dy_en=0 for exactly 2 cycles, covering the integrator's 2-cycle run latency. y holds the initial condition. Then go to RUN.
- RUN: dy_en=1. Each dy_en=1 cycle is one step.
  - Step counter steps_done increments every step.
  - Decimation counter wraps at decim. On wrap, a capture is scheduled for the following cycle, when y_in reflects that step.
  - Capture loads y_in into the 1-entry output register and sets sample_valid.
- Back-pressure:
  - If a capture is due while sample_valid=1 and sample_ready=0, the controller enters WAIT.
  - WAIT: dy_en=0, so y freezes; int_run stays 1. Return to RUN on the cycle after the pending sample is accepted.
  - No sample is ever dropped or overwritten.
- When steps_done reaches num_steps: dy_en=0, go to DRAIN.
- DRAIN: perform the final capture if one is due. Wait until sample_valid=0, then go to DONE.
  - If num_steps is not a multiple of decim, the last partial interval is not sampled.
- DONE: done=1 for one cycle, int_run=0, then go to IDLE. busy=1 in every state except IDLE.
- start while busy: ignored.
- Arithmetic:
  - Counters are unsigned, with no wrap inside a run, since num_steps ≤ 2^STEP_W−1.
  - sample_data is y_in verbatim. No extension or truncation.

## Timing
- Reset values: int_run=0, dy_en=0, busy=0, done=0, sample_valid=0, sample_data=0, state=IDLE, all counters 0.
- Reset asserted mid-run: all outputs return to reset values asynchronously. The integrator reloads its initial condition 2 cycles after int_run falls.
- start accepted at edge T:
  - PRIME during T+1..T+2.
  - First dy_en=1 at T+3.
- Sample capture:
  - First sample_valid rises at T+3+decim, with no stall.
  - Sample k equals y after k·decim steps.
- Handshake: a transfer occurs on an edge where sample_valid=1 and sample_ready=1.
  - sample_valid and sample_data are stable while sample_valid=1 and sample_ready=0.
  - Capture and accept on the same edge: the register takes the new sample and sample_valid stays 1.
- Throughput: with sample_ready held 1, a run of N steps takes N+5 cycles from start to done (N≥1).

## Configuration
- ODE_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in any non-IDLE state forces IDLE on the next edge. int_run=0, dy_en=0, sample_valid=0 (pending sample discarded), no done pulse.
  - In IDLE, abort has no effect.
- ODE_ABORT_EN undefined: there is no abort port, and a run always completes.

## Test plan
- Reset, then start with num_steps=8, decim=2, y_in modelled by the integrator with IC=100 and dy=128 (DELTA=7). Required: 4 samples 102, 104, 106, 108; done pulses 13 cycles after start.
- num_steps=0: required: busy high 1 cycle, done pulse, no samples, dy_en never asserted.
- num_steps=6, decim=1, sample_ready low for 5 cycles at the 2nd sample. Required: dy_en low during the stall, no lost or duplicated sample, sample values contiguous.
- decim=0 versus decim=1 with identical stimulus. Required: identical sample streams.
- master_rst asserted in RUN. Required: int_run=0 and sample_valid=0 immediately (asynchronously). A start after release behaves like the first test.
- With ODE_ABORT_EN: abort in WAIT. Required: next edge IDLE, sample_valid=0, no done; a subsequent run is correct.
